// File: rtl/hwpe_sel_ctrl.sv
// Sequences the shared HWPE select/enable pair: switches or disables only once the
// active HWPE is idle with no config-bus transactions in flight, and blocks the bus while settling.
module hwpe_sel_ctrl #(
  parameter  int unsigned MAX_NUM_HWPES   = 4,
  parameter  int unsigned N_HWPES         = 2,
  parameter  int unsigned MAX_OUTSTANDING = 4,
  parameter  int unsigned SETTLE_CYCLES   = 2,
  localparam int unsigned SW              = $clog2(MAX_NUM_HWPES),
  localparam int unsigned OW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [SW-1:0] req_sel_i,
  input  logic          req_en_i,
  input  logic          busy_i,
  input  logic          cfg_req_i,
  input  logic          cfg_gnt_i,
  input  logic          cfg_r_valid_i,
  output logic          cfg_block_o,
  output logic [SW-1:0] hwpe_sel_o,
  output logic          hwpe_en_o,
  output logic [OW-1:0] outstanding_o,
  output logic          err_o
);

  localparam int unsigned STW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_SETTLE,
    ST_ON,
    ST_DRAIN,
    ST_GATE
  } state_e;

  state_e          state_q;
  logic [SW-1:0]   sel_q;
  logic            en_q;
  logic            block_q;
  logic            err_q;
  logic [OW-1:0]   cnt_q, cnt_d;
  logic [STW-1:0]  settle_q;
  logic [SW-1:0]   pend_sel_q;
  logic            pend_en_q;

  logic accept, illegal, inc, dec, underflow, saturated;

  assign saturated     = (cnt_q == OW'(MAX_OUTSTANDING));
  assign cfg_block_o   = block_q | saturated;
  assign req_ready_o   = (state_q == ST_OFF) || (state_q == ST_ON);
  assign hwpe_sel_o    = sel_q;
  assign hwpe_en_o     = en_q;
  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

  assign accept  = req_valid_i & req_ready_o;
  assign illegal = (32'(req_sel_i) >= 32'(N_HWPES));

  // A transfer only counts when it actually reaches the subsystem.
  assign inc       = cfg_req_i & cfg_gnt_i & ~cfg_block_o;
  assign dec       = cfg_r_valid_i;
  assign underflow = dec & ~inc & (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec) begin
      cnt_d = cnt_q + OW'(1);
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - OW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_OFF;
      sel_q      <= '0;
      en_q       <= 1'b0;
      block_q    <= 1'b1;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      settle_q   <= '0;
      pend_sel_q <= '0;
      pend_en_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= underflow | (accept & illegal);

      unique case (state_q)
        ST_OFF: begin
          if (accept && !illegal) begin
            sel_q <= req_sel_i;
            if (req_en_i) begin
              en_q     <= 1'b1;
              settle_q <= STW'(SETTLE_CYCLES);
              state_q  <= ST_SETTLE;
            end
          end
        end

        ST_SETTLE: begin
          if (settle_q <= STW'(1)) begin
            block_q <= 1'b0;
            state_q <= ST_ON;
          end else begin
            settle_q <= settle_q - STW'(1);
          end
        end

        ST_ON: begin
          if (accept && !illegal && !(req_en_i && (req_sel_i == sel_q))) begin
            pend_sel_q <= req_sel_i;
            pend_en_q  <= req_en_i;
            block_q    <= 1'b1;
            state_q    <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          // Select moves together with the enable falling, never while enabled.
          if (!busy_i && (cnt_q == '0)) begin
            en_q    <= 1'b0;
            sel_q   <= pend_sel_q;
            state_q <= ST_GATE;
          end
        end

        ST_GATE: begin
          if (pend_en_q) begin
            en_q     <= 1'b1;
            settle_q <= STW'(SETTLE_CYCLES);
            state_q  <= ST_SETTLE;
          end else begin
            state_q  <= ST_OFF;
          end
        end

        default: state_q <= ST_OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_hwpe_sel_ctrl.sv
// Directed, table-driven check of hwpe_sel_ctrl: select/enable sequencing, outstanding
// counter saturation and underflow, illegal selects, and asynchronous reset mid-drain.
module tb_hwpe_sel_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid_i;
  logic       req_ready_o;
  logic [1:0] req_sel_i;
  logic       req_en_i;
  logic       busy_i;
  logic       cfg_req_i;
  logic       cfg_gnt_i;
  logic       cfg_r_valid_i;
  logic       cfg_block_o;
  logic [1:0] hwpe_sel_o;
  logic       hwpe_en_o;
  logic [2:0] outstanding_o;
  logic       err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hwpe_sel_ctrl #(
    .MAX_NUM_HWPES  (4),
    .N_HWPES        (2),
    .MAX_OUTSTANDING(4),
    .SETTLE_CYCLES  (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_sel_i    (req_sel_i),
    .req_en_i     (req_en_i),
    .busy_i       (busy_i),
    .cfg_req_i    (cfg_req_i),
    .cfg_gnt_i    (cfg_gnt_i),
    .cfg_r_valid_i(cfg_r_valid_i),
    .cfg_block_o  (cfg_block_o),
    .hwpe_sel_o   (hwpe_sel_o),
    .hwpe_en_o    (hwpe_en_o),
    .outstanding_o(outstanding_o),
    .err_o        (err_o)
  );

  // Inputs for one cycle and the outputs expected just after that cycle's edge.
  typedef struct {
    logic       v;
    logic [1:0] sel;
    logic       en;
    logic       busy;
    logic       creq;
    logic       gnt;
    logic       rv;
    logic       e_rdy;
    logic       e_blk;
    logic [1:0] e_sel;
    logic       e_en;
    logic [2:0] e_out;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [1:0] sel, input logic en, input logic busy,
                     input logic creq, input logic gnt, input logic rv,
                     input logic e_rdy, input logic e_blk, input logic [1:0] e_sel,
                     input logic e_en, input logic [2:0] e_out, input logic e_err);
    vec_t t;
    t.v = v; t.sel = sel; t.en = en; t.busy = busy; t.creq = creq; t.gnt = gnt; t.rv = rv;
    t.e_rdy = e_rdy; t.e_blk = e_blk; t.e_sel = e_sel; t.e_en = e_en; t.e_out = e_out;
    t.e_err = e_err;
    vecs.push_back(t);
  endtask

  task automatic check_outs(input string name, input logic [8:0] exp);
    logic [8:0] got;
    got = {req_ready_o, cfg_block_o, hwpe_sel_o, hwpe_en_o, outstanding_o, err_o};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got rdy/blk/sel/en/out/err=%b/%b/%0d/%b/%0d/%b required %b/%b/%0d/%b/%0d/%b",
               name, got[8], got[7], got[6:5], got[4], got[3:1], got[0],
               exp[8], exp[7], exp[6:5], exp[4], exp[3:1], exp[0]);
    end else begin
      $display("ok   %s rdy=%b blk=%b sel=%0d en=%b out=%0d err=%b",
               name, got[8], got[7], got[6:5], got[4], got[3:1], got[0]);
    end
  endtask

  task automatic drive_idle();
    req_valid_i = 0; req_sel_i = 0; req_en_i = 0; busy_i = 0;
    cfg_req_i = 0; cfg_gnt_i = 0; cfg_r_valid_i = 0;
  endtask

  initial begin
    //   v sel en bsy crq gnt rv | rdy blk sel en out err
    // Power up on HWPE 1, settle for 2 cycles.
    add(1, 1, 1, 0, 0, 0, 0,   0, 1, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,   1, 0, 1, 1, 0, 0);
    // Outstanding counting and saturation.
    add(0, 0, 0, 0, 1, 1, 0,   1, 0, 1, 1, 1, 0);
    add(0, 0, 0, 0, 1, 1, 0,   1, 0, 1, 1, 2, 0);
    add(0, 0, 0, 0, 1, 1, 0,   1, 0, 1, 1, 3, 0);
    add(0, 0, 0, 0, 1, 1, 1,   1, 0, 1, 1, 3, 0);
    add(0, 0, 0, 0, 1, 1, 0,   1, 1, 1, 1, 4, 0);
    add(0, 0, 0, 0, 1, 1, 0,   1, 1, 1, 1, 4, 0);
    add(0, 0, 0, 0, 0, 0, 1,   1, 0, 1, 1, 3, 0);
    add(0, 0, 0, 0, 0, 0, 1,   1, 0, 1, 1, 2, 0);
    add(0, 0, 0, 0, 0, 0, 1,   1, 0, 1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1,   1, 0, 1, 1, 0, 0);
    // Switch to HWPE 0 while busy with 2 in flight.
    add(0, 0, 0, 0, 1, 1, 0,   1, 0, 1, 1, 1, 0);
    add(0, 0, 0, 0, 1, 1, 0,   1, 0, 1, 1, 2, 0);
    add(1, 0, 1, 1, 0, 0, 0,   0, 1, 1, 1, 2, 0);
    add(0, 0, 0, 1, 0, 0, 1,   0, 1, 1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1,   0, 1, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0);
    // Same-select enable is a no-op; illegal select pulses err only.
    add(1, 0, 1, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0);
    add(1, 3, 1, 0, 0, 0, 0,   1, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0);
    // Disable: DRAIN -> GATE -> OFF.
    add(1, 0, 0, 0, 0, 0, 0,   0, 1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0);
    // Illegal select in OFF, then response underflow.
    add(1, 3, 1, 0, 0, 0, 0,   1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1,   1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0);
    // Select without enable in OFF, then enable; end in DRAIN with 2 in flight.
    add(1, 1, 0, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 0,   0, 1, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,   1, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0,   1, 0, 1, 1, 1, 0);
    add(0, 0, 0, 0, 1, 1, 0,   1, 0, 1, 1, 2, 0);
    add(1, 0, 1, 1, 0, 0, 0,   0, 1, 1, 1, 2, 0);

    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 9'b1_1_00_0_000_0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      req_valid_i   = vecs[i].v;
      req_sel_i     = vecs[i].sel;
      req_en_i      = vecs[i].en;
      busy_i        = vecs[i].busy;
      cfg_req_i     = vecs[i].creq;
      cfg_gnt_i     = vecs[i].gnt;
      cfg_r_valid_i = vecs[i].rv;
      @(posedge clk);
      #1;
      check_outs($sformatf("vec%0d", i),
                 {vecs[i].e_rdy, vecs[i].e_blk, vecs[i].e_sel, vecs[i].e_en,
                  vecs[i].e_out, vecs[i].e_err});
    end

    // Asynchronous reset while draining: outputs must drop before any clock edge.
    drive_idle();
    busy_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async_reset_drain", 9'b1_1_00_0_000_0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outs("after_reset_release", 9'b1_1_00_0_000_0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
